// File: rtl/riscv_data_mem_if.sv
// Request/response bus between the load/store unit (master) and the data memory (slave).
// err_o exists only when RISCV_DMEM_ERR_EN is defined.
interface riscv_data_mem_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wd_i;
    logic [31:0] rd_o;
    logic        ready_o;
`ifdef RISCV_DMEM_ERR_EN
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wd_i,
        input  rd_o, ready_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wd_i,
        output rd_o, ready_o, err_o
    );
`else
    modport master (
        output req_i, we_i, be_i, addr_i, wd_i,
        input  rd_o, ready_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wd_i,
        output rd_o, ready_o
    );
`endif
endinterface

// File: rtl/riscv_data_mem.sv
// Word-organised data memory with a one-outstanding-request handshake and LATENCY wait states.
// Optional range checking and err_o are enabled by defining RISCV_DMEM_ERR_EN.
module riscv_data_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    riscv_data_mem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic [31:0]       rd_q, rd_d;
    logic [IDX_W-1:0]  idx;
    logic              capture;
    logic              access;
    logic              oor;
    logic              mem_we;

    logic [31:0]       mem [DEPTH_WORDS];

`ifdef RISCV_DMEM_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0]       addr_q;

    assign idx = addr_q[IDX_W+1:2];
    assign oor = ({1'b0, addr_q} >= ADDR_LIMIT);
`else
    logic [IDX_W-1:0]  idx_q;
    logic              addr_unused;

    // Only the word-index bits matter; the rest wrap away by design.
    assign addr_unused = ^bus.addr_i;
    assign idx         = idx_q;
    assign oor         = 1'b0;
`endif

    assign access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign mem_we = access && we_q && !oor;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        rd_d    = rd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    capture = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!we_q) begin
                        rd_d = oor ? 32'h0 : mem[idx];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wd_q    <= 32'h0;
`ifdef RISCV_DMEM_ERR_EN
            addr_q  <= 32'h0;
`else
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            if (capture) begin
                we_q <= bus.we_i;
                be_q <= bus.be_i;
                wd_q <= bus.wd_i;
`ifdef RISCV_DMEM_ERR_EN
                addr_q <= bus.addr_i;
`else
                idx_q  <= bus.addr_i[IDX_W+1:2];
`endif
            end
        end
    end

    // NOTE: storage has no reset; a cancelled transaction is stopped by the FSM never reaching access.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be_q[k]) begin
                    mem[idx][8*k +: 8] <= wd_q[8*k +: 8];
                end
            end
        end
    end

    assign bus.ready_o = (state_q == DONE);
    assign bus.rd_o    = rd_q;
`ifdef RISCV_DMEM_ERR_EN
    assign bus.err_o   = (state_q == DONE) && oor;
`endif

endmodule

// File: tb/tb_riscv_data_mem.sv
// Scoreboard bench: stimulus pushes expected completions, per-instance monitors pop and compare.
// Two instances cover LATENCY=2 and LATENCY=0; error checks apply when RISCV_DMEM_ERR_EN is defined.
module tb_riscv_data_mem;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q2[$];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_data_mem_if bus0();
    riscv_data_mem_if bus2();

    riscv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0.slave)
    );

    riscv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus2.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic logic rdy(input int d);
        return (d == 1) ? bus2.ready_o : bus0.ready_o;
    endfunction

    task automatic drive(input int d, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (d == 1) begin
            bus2.req_i = req; bus2.we_i = we; bus2.be_i = be; bus2.addr_i = addr; bus2.wd_i = wd;
        end else begin
            bus0.req_i = req; bus0.we_i = we; bus0.be_i = be; bus0.addr_i = addr; bus0.wd_i = wd;
        end
    endtask

    // Monitor side: pop the oldest expectation and compare timing, data and error flag.
    task automatic mon(input int d, input logic [31:0] rd, input logic err);
        exp_t e;
        if ((d == 1 && q2.size() == 0) || (d == 0 && q0.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready dut%0d: got ready_o=1, expected 0 (t=%0t)", lat(d), $time);
        end else begin
            e = (d == 1) ? q2.pop_front() : q0.pop_front();
            check($sformatf("latency_dut%0d", lat(d)), 32'(cyc), 32'(e.cyc));
            check($sformatf("rd_dut%0d", lat(d)), rd, e.rd);
`ifdef RISCV_DMEM_ERR_EN
            check($sformatf("err_dut%0d", lat(d)), {31'h0, err}, {31'h0, e.err});
`endif
        end
    endtask

`ifdef RISCV_DMEM_ERR_EN
    always @(negedge clk) begin
        if (bus2.ready_o === 1'b1) mon(1, bus2.rd_o, bus2.err_o);
        else check("err_idle_dut2", {31'h0, bus2.err_o}, 32'h0);
    end
    always @(negedge clk) begin
        if (bus0.ready_o === 1'b1) mon(0, bus0.rd_o, bus0.err_o);
        else check("err_idle_dut0", {31'h0, bus0.err_o}, 32'h0);
    end
`else
    always @(negedge clk) if (bus2.ready_o === 1'b1) mon(1, bus2.rd_o, 1'b0);
    always @(negedge clk) if (bus0.ready_o === 1'b1) mon(0, bus0.rd_o, 1'b0);
`endif

    // Stimulus side: issue one request, push its expected completion, wait (bounded) for ready_o.
    // chained: called at the negedge of the previous ready_o with req_i still high.
    task automatic txn(input int d, input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd_exp, input bit err_exp,
                       input bit chained, input bit hold, input bit scramble);
        exp_t e;
        int   n;
        if (!chained) begin
            @(posedge clk);
            #1;
            e.cyc = cyc + 2 + lat(d);
        end else begin
            e.cyc = cyc + 3 + lat(d);
        end
        drive(d, 1'b1, we, be, addr, wd);
        e.rd  = we ? last_rd[d] : rd_exp;
        e.err = err_exp;
        if (!we) last_rd[d] = rd_exp;
        if (d == 1) q2.push_back(e);
        else        q0.push_back(e);
        if (scramble) begin
            @(posedge clk);
            #1;
            drive(d, 1'b1, ~we, ~be, ~addr, ~wd);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(d) && n < 40);
        if (!rdy(d)) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d: got no ready_o, expected one within 40 cycles", lat(d));
        end
        if (!hold) drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready_dut2", {31'h0, bus2.ready_o}, 32'h0);
        check("reset_rd_dut2", bus2.rd_o, 32'h0);
        check("reset_ready_dut0", {31'h0, bus0.ready_o}, 32'h0);
        check("reset_rd_dut0", bus0.rd_o, 32'h0);
        rst_n = 1'b1;

        // LATENCY=2: full write/read, partial write with payload scrambled after capture, be=0 write.
        txn(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0);
        txn(1, 0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
        txn(1, 1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0, 0, 0, 0);
        txn(1, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 0, 0, 0, 1);
        txn(1, 0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 0, 0, 0, 0);
        txn(1, 1, 4'h0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0);
        txn(1, 0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);

`ifdef RISCV_DMEM_ERR_EN
        txn(1, 1, 4'hF, 32'h0, 32'h0BADF00D, 32'h0, 0, 0, 0, 0);
        txn(1, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 1, 0, 0, 0);
        txn(1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0);
        txn(1, 0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 0, 0, 0, 0);
`else
        txn(1, 1, 4'hF, 32'h1004, 32'hCAFE0001, 32'h0, 0, 0, 0, 0);
        txn(1, 0, 4'h0, 32'h4, 32'h0, 32'hCAFE0001, 0, 0, 0, 0);
`endif

        // LATENCY=0: preload, then two back-to-back reads with req_i held high throughout.
        txn(0, 1, 4'hF, 32'h0, 32'h01020304, 32'h0, 0, 0, 0, 0);
        txn(0, 1, 4'hF, 32'h4, 32'hA0B0C0D0, 32'h0, 0, 0, 0, 0);
        txn(0, 0, 4'h0, 32'h0, 32'h0, 32'h01020304, 0, 0, 1, 0);
        txn(0, 0, 4'h0, 32'h4, 32'h0, 32'hA0B0C0D0, 0, 1, 0, 0);

        // Reset in the middle of a LATENCY=2 write must cancel it.
        txn(1, 1, 4'hF, 32'h8, 32'h55AA55AA, 32'h0, 0, 0, 0, 0);
        txn(1, 0, 4'h0, 32'h8, 32'h0, 32'h55AA55AA, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b1, 4'hF, 32'h8, 32'h12345678);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        check("midbusy_reset_ready_dut2", {31'h0, bus2.ready_o}, 32'h0);
        check("midbusy_reset_rd_dut2", bus2.rd_o, 32'h0);
        check("midbusy_reset_rd_dut0", bus0.rd_o, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_hold_ready_dut2", {31'h0, bus2.ready_o}, 32'h0);
        rst_n = 1'b1;
        txn(1, 0, 4'h0, 32'h8, 32'h0, 32'h55AA55AA, 0, 0, 0, 0);

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 32'(q0.size() + q2.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
